// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep, WIDTH-wide register chain between processor
// pipeline stages. Each stage carries a valid bit. A leading group of stages
// can be held, with a bubble inserted behind the held group. Any stage can be
// flushed, and a synchronous clear empties the whole chain. Every stage is
// visible on the outputs so hazard and forwarding logic can see it.
module pipe_stage_chain #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int NEG_EDGE = 0,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [CW-1:0]          hold_upto,
  input  logic [DEPTH-1:0]       flush,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [CW-1:0]          occupancy
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic [CW-1:0]    h;

  // Clamp the hold count: any value past the last stage means "hold everything".
  always_comb begin
    h = (hold_upto > CW'(DEPTH)) ? CW'(DEPTH) : hold_upto;
  end

  // Next-state contents of every stage for a normal (enabled, not cleared) edge.
  always_comb begin
    // Stage 0 either holds (optionally flushed) or takes the input entry.
    vld_d[0] = 1'b0;
    dat_d[0] = '0;
    if (h != '0) begin
      if (!flush[0]) begin
        vld_d[0] = vld_q[0];
        dat_d[0] = dat_q[0];
      end
    end else begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
    end
    // Later stages hold, become the bubble right behind the held group,
    // or shift in the previous stage's entry (killed if that one is flushed).
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = 1'b0;
      dat_d[i] = '0;
      if (CW'(i) < h) begin
        if (!flush[i]) begin
          vld_d[i] = vld_q[i];
          dat_d[i] = dat_q[i];
        end
      end else if (CW'(i) > h) begin
        if (!flush[i-1]) begin
          vld_d[i] = vld_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
    end
  end

  // Stage registers on the selected capture edge: clear beats freeze beats update.
  generate
    if (NEG_EDGE != 0) begin : g_neg
      always_ff @(negedge clk) begin
        if (clr) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (en) begin
          vld_q <= vld_d;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk) begin
        if (clr) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (en) begin
          vld_q <= vld_d;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
        end
      end
    end
  endgenerate

  // Expose every stage and count the live entries straight from the registers.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*WIDTH +: WIDTH] = dat_q[i];
      occupancy = occupancy + CW'(vld_q[i]);
    end
  end

  assign stage_valid = vld_q;
  assign out_valid   = vld_q[DEPTH-1];
  assign out_data    = dat_q[DEPTH-1];
  assign in_ready    = en && (hold_upto == '0);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain. A rising-edge and a falling-edge instance share
// the same inputs. Each is compared with its own array model of the stage
// rules after its own capture edge.
module tb_pipe_stage_chain;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clr, en, in_valid;
  logic [W-1:0]    in_data;
  logic [CW-1:0]   hold_upto;
  logic [D-1:0]    flush;

  logic [1:0]             ir, ov;
  logic [1:0][W-1:0]      od;
  logic [1:0][D-1:0]      sv;
  logic [1:0][D*W-1:0]    sd;
  logic [1:0][CW-1:0]     occ;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .NEG_EDGE(0), .CW(CW)) u_pos (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid), .in_data(in_data),
    .hold_upto(hold_upto), .flush(flush), .in_ready(ir[0]), .out_valid(ov[0]),
    .out_data(od[0]), .stage_valid(sv[0]), .stage_data(sd[0]), .occupancy(occ[0]));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .NEG_EDGE(1), .CW(CW)) u_neg (
    .clk(clk), .clr(clr), .en(en), .in_valid(in_valid), .in_data(in_data),
    .hold_upto(hold_upto), .flush(flush), .in_ready(ir[1]), .out_valid(ov[1]),
    .out_data(od[1]), .stage_valid(sv[1]), .stage_data(sd[1]), .occupancy(occ[1]));

  int checks = 0;
  int failures = 0;

  // Reference model: m_v/m_d[dut][stage].
  logic         m_v [2][D];
  logic [W-1:0] m_d [2][D];

  task automatic chk(input string tag, input logic [D*W-1:0] obs, input logic [D*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one capture edge to the model of dut idx using the stage rules.
  task automatic model_edge(input int idx);
    logic         ov_old [D];
    logic [W-1:0] od_old [D];
    int hh;
    for (int i = 0; i < D; i++) begin
      ov_old[i] = m_v[idx][i];
      od_old[i] = m_d[idx][i];
    end
    if (clr) begin
      for (int i = 0; i < D; i++) begin m_v[idx][i] = 1'b0; m_d[idx][i] = '0; end
    end else if (en) begin
      hh = (int'(hold_upto) > D) ? D : int'(hold_upto);
      for (int i = 0; i < D; i++) begin
        if (i < hh) begin
          if (flush[i]) begin m_v[idx][i] = 1'b0; m_d[idx][i] = '0; end
        end else if (i == hh && hh > 0) begin
          m_v[idx][i] = 1'b0; m_d[idx][i] = '0;
        end else if (i == 0) begin
          m_v[idx][0] = in_valid; m_d[idx][0] = in_data;
        end else if (flush[i-1]) begin
          m_v[idx][i] = 1'b0; m_d[idx][i] = '0;
        end else begin
          m_v[idx][i] = ov_old[i-1]; m_d[idx][i] = od_old[i-1];
        end
      end
    end
  endtask

  task automatic check_dut(input int idx);
    logic [D*W-1:0] e_sd;
    logic [D-1:0]   e_sv;
    int             cnt;
    string          p;
    p = (idx == 0) ? "pos" : "neg";
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      e_sd[i*W +: W] = m_d[idx][i];
      e_sv[i] = m_v[idx][i];
      cnt += int'(m_v[idx][i]);
    end
    chk({p, ".stage_valid"}, {'0, sv[idx]}, {'0, e_sv});
    chk({p, ".stage_data"},  sd[idx], e_sd);
    chk({p, ".out_valid"},   {'0, ov[idx]}, {'0, m_v[idx][D-1]});
    chk({p, ".out_data"},    {'0, od[idx]}, {'0, m_d[idx][D-1]});
    chk({p, ".occupancy"},   {'0, occ[idx]}, (D*W)'(cnt));
  endtask

  task automatic check_ready();
    logic e;
    #1;
    e = en && (hold_upto == 0);
    chk("pos.in_ready", {'0, ir[0]}, {'0, e});
    chk("neg.in_ready", {'0, ir[1]}, {'0, e});
  endtask

  // One clock period: falling edge for u_neg, then rising edge for u_pos.
  task automatic step();
    @(negedge clk);
    model_edge(1);
    #1 check_dut(1);
    @(posedge clk);
    model_edge(0);
    #1 check_dut(0);
  endtask

  task automatic set_in(input logic c, input logic e, input logic v,
                        input logic [W-1:0] d, input logic [CW-1:0] h,
                        input logic [D-1:0] f);
    clr = c; en = e; in_valid = v; in_data = d; hold_upto = h; flush = f;
  endtask

  initial begin
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < D; i++) begin m_v[j][i] = 1'b0; m_d[j][i] = '0; end
    set_in(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step();

    // Streaming A0..A7 with no holds.
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 1'b1, 1'b1, W'(32'hA0 + k), '0, '0);
      check_ready();
      step();
      if (k >= 3) begin
        chk("stream.out_data",  {'0, od[0]}, (D*W)'(32'hA0 + k - 3));
        chk("stream.out_valid", {'0, ov[0]}, (D*W)'(1));
        chk("stream.occupancy", {'0, occ[0]}, (D*W)'(4));
      end
    end

    // Partial stall with B0..B3 loaded.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b1, W'(32'hB0 + k), '0, '0);
      step();
    end
    set_in(1'b0, 1'b1, 1'b1, 32'hDEAD, 3'd2, '0);
    check_ready();
    chk("stall.in_ready", {'0, ir[0]}, '0);
    step();
    chk("stall.stage_data", sd[0], {32'hB1, 32'h0, 32'hB2, 32'hB3});
    chk("stall.stage_valid", {'0, sv[0]}, (D*W)'(4'b1011));
    chk("stall.occupancy", {'0, occ[0]}, (D*W)'(3));

    // Flush of stages 1 and 2 on a full chain.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b1, W'(32'hC0 + k), '0, '0);
      step();
    end
    set_in(1'b0, 1'b1, 1'b1, 32'hC4, '0, 4'b0110);
    step();
    chk("flush.stage_data", sd[0], {32'h0, 32'h0, 32'hC3, 32'hC4});
    chk("flush.stage_valid", {'0, sv[0]}, (D*W)'(4'b0011));

    // Freeze with flush and input asserted, then clear while frozen.
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b0, 1'b1, 32'h5555, '0, 4'b1111);
      check_ready();
      step();
    end
    chk("freeze.stage_data", sd[0], {32'h0, 32'h0, 32'hC3, 32'hC4});
    set_in(1'b1, 1'b0, 1'b1, 32'h7777, 3'd2, 4'b1111);
    step();
    chk("clr.stage_data", sd[0], '0);
    chk("clr.occupancy", {'0, occ[0]}, '0);

    // Randomised traffic including holds past DEPTH, flushes and clears.
    for (int k = 0; k < 300; k++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
             1'($urandom), W'($urandom),
             ($urandom_range(0, 9) < 5) ? CW'(0) : CW'($urandom_range(1, 7)),
             ($urandom_range(0, 3) == 0) ? D'($urandom) : D'(0));
      check_ready();
      step();
    end

    // Refill, then a clr pulse that sees no edge of either polarity.
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b1, W'(32'hE0 + k), '0, '0);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    clr = 1'b1;
    #2 clr = 1'b0;
    #1 check_dut(0);
    check_dut(1);
    step();
    chk("glitch.neg_data", sd[1], {32'hE0, 32'hE1, 32'hE2, 32'hE3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
